// File: rtl/mtx_mvmul_unit.sv
// mtx_mvmul_unit: ternary 16x16 matrix times signed Q-format vector, one saturated row per cycle
module mtx_mvmul_unit #(
  parameter int Q = 23,
  parameter int INT = 8,
  parameter int R = 16,
  parameter int C = 16,
  localparam int TOTAL = INT + Q + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*R*C-1:0]     mtx_in,
  input  logic [TOTAL*C-1:0]   vec_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TOTAL*R-1:0]   vec_out,
  output logic [3:0]           status_out,
  output logic                 busy
);
  localparam int ACC = TOTAL + 5;
  localparam int RW = $clog2(R);
  localparam logic signed [ACC-1:0] MAXV = {{(ACC-TOTAL+1){1'b0}}, {(TOTAL-1){1'b1}}};
  localparam logic signed [ACC-1:0] MINV = {{(ACC-TOTAL+1){1'b1}}, {(TOTAL-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                  state_q;
  logic [RW-1:0]           row_q;
  logic [2*R*C-1:0]        mtx_q;
  logic [TOTAL*C-1:0]      vec_q;
  logic [TOTAL*R-1:0]      res_q;
  logic                    of_q, uf_q, inv_q;
  logic                    in_ready_q, out_valid_q, busy_q;
  logic signed [ACC-1:0]   acc, x;
  logic [1:0]              code;
  logic                    row_inv, hi, lo;
  logic [TOTAL-1:0]        sat;
  // Row dot product: each ternary weight adds, subtracts or skips the widened vector element
  always_comb begin
    acc = '0;
    x = '0;
    code = '0;
    row_inv = 1'b0;
    for (int c = 0; c < C; c++) begin
      code = mtx_q[(int'(row_q)*C+c)*2 +: 2];
      x = {{(ACC-TOTAL){vec_q[c*TOTAL+TOTAL-1]}}, vec_q[c*TOTAL +: TOTAL]};
      acc = acc + (code == 2'b01 ? x : code == 2'b10 ? -x : '0);
      row_inv = row_inv | (code == 2'b11);
    end
  end
  assign hi = acc > MAXV;
  assign lo = acc < MINV;
  assign sat = hi ? MAXV[TOTAL-1:0] : lo ? MINV[TOTAL-1:0] : acc[TOTAL-1:0];
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy = busy_q;
  assign vec_out = res_q;
  assign status_out = out_valid_q ? {of_q, uf_q, ~|res_q, inv_q} : 4'b0;
  // Operand capture; only the registered copies feed the datapath
  always_ff @(posedge clk)
    if (state_q == IDLE && in_valid) begin
      mtx_q <= mtx_in;
      vec_q <= vec_in;
    end
  // Control FSM: accept, sweep rows, hold result until the consumer takes it
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      row_q <= '0;
      res_q <= '0;
      {of_q, uf_q, inv_q} <= '0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else
      case (state_q)
        IDLE:
          if (in_valid) begin
            state_q <= RUN;
            row_q <= '0;
            {of_q, uf_q, inv_q} <= '0;
            in_ready_q <= 1'b0;
            busy_q <= 1'b1;
          end
        RUN: begin
          res_q[int'(row_q)*TOTAL +: TOTAL] <= sat;
          of_q <= of_q | hi;
          uf_q <= uf_q | lo;
          inv_q <= inv_q | row_inv;
          row_q <= row_q + RW'(1);
          if (row_q == RW'(R-1)) begin
            state_q <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE:
          if (out_ready) begin
            state_q <= IDLE;
            out_valid_q <= 1'b0;
            busy_q <= 1'b0;
            in_ready_q <= 1'b1;
          end
        default: state_q <= IDLE;
      endcase
endmodule

// File: tb/tb_mtx_mvmul_unit.sv
// tb_mtx_mvmul_unit: scoreboard bench with an arithmetic reference model for mtx_mvmul_unit
module tb_mtx_mvmul_unit;
  localparam int R = 16;
  localparam int C = 16;
  localparam int T = 32;
  typedef struct {
    logic [T*R-1:0] v;
    logic [3:0]     st;
  } exp_t;
  logic clk, rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2*R*C-1:0] mtx_in;
  logic [T*C-1:0]   vec_in;
  logic [T*R-1:0]   vec_out;
  logic [3:0]       status_out;
  exp_t q[$];
  int total = 0;
  int passed = 0;

  mtx_mvmul_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mtx_in(mtx_in), .vec_in(vec_in), .out_valid(out_valid), .out_ready(out_ready),
    .vec_out(vec_out), .status_out(status_out), .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string n, input logic [T*R-1:0] got, input logic [T*R-1:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, got, exp);
  endtask

  // Reference: plain integer sum of +x / -x / 0 per weight, then clip to 32-bit signed
  function automatic exp_t model(input logic [2*R*C-1:0] m, input logic [T*C-1:0] v);
    exp_t e;
    logic [1:0] code;
    logic signed [T-1:0] xs;
    longint s;
    bit of = 0, uf = 0, inv = 0;
    e.v = '0;
    for (int r = 0; r < R; r++) begin
      s = 0;
      for (int c = 0; c < C; c++) begin
        code = m[(r*C+c)*2 +: 2];
        xs = v[c*T +: T];
        if (code == 2'd1) s += longint'(xs);
        else if (code == 2'd2) s -= longint'(xs);
        else if (code == 2'd3) inv = 1;
      end
      if (s > 64'sd2147483647) begin s = 64'sd2147483647; of = 1; end
      if (s < -64'sd2147483648) begin s = -64'sd2147483648; uf = 1; end
      e.v[r*T +: T] = s[T-1:0];
    end
    e.st = {of, uf, e.v == '0, inv};
    return e;
  endfunction

  function automatic logic [2*R*C-1:0] mfill(input logic [1:0] code);
    logic [2*R*C-1:0] m;
    for (int i = 0; i < R*C; i++) m[i*2 +: 2] = code;
    return m;
  endfunction

  function automatic logic [T*C-1:0] vfill(input logic [T-1:0] x);
    logic [T*C-1:0] v;
    for (int c = 0; c < C; c++) v[c*T +: T] = x;
    return v;
  endfunction

  function automatic logic [2*R*C-1:0] rmtx();
    logic [2*R*C-1:0] m;
    int k;
    for (int i = 0; i < R*C; i++) begin
      k = $urandom_range(0, 19);
      m[i*2 +: 2] = k < 8 ? 2'd0 : k < 13 ? 2'd1 : k < 18 ? 2'd2 : 2'd3;
    end
    return m;
  endfunction

  function automatic logic [T*C-1:0] rvec();
    logic [T*C-1:0] v;
    int k;
    for (int c = 0; c < C; c++) begin
      k = $urandom_range(0, 5);
      v[c*T +: T] = k < 2 ? T'($urandom) : k < 4 ? T'($urandom_range(0, 32'h00FFFFFF)) - 32'h00800000 :
                    k == 4 ? 32'h7FFFFFFF : 32'h80000000;
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands until accepted; the expected result is queued at acceptance
  task automatic issue(input logic [2*R*C-1:0] m, input logic [T*C-1:0] v, input bit push, input bit rnd);
    bit acc = 0;
    in_valid = 1;
    mtx_in = m;
    vec_in = v;
    for (int i = 0; i < 300 && !acc; i++) begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_ready;
      step();
    end
    in_valid = 0;
    mtx_in = rmtx();
    vec_in = rvec();
    chk("accept", {511'b0, acc}, 512'd1);
    if (acc && push) q.push_back(model(m, v));
  endtask

  task automatic drain(input bit rnd);
    for (int i = 0; i < 400 && q.size() != 0; i++) begin
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      step();
    end
    out_ready = 1;
    chk("drain", 512'(q.size()), 512'd0);
  endtask

  // Monitor: every accepted result is compared against the oldest queued expectation
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", 512'd1, 512'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("vec_out", vec_out, e.v);
        chk("status", 512'(status_out), 512'(e.st));
      end
    end

  initial begin
    logic [2*R*C-1:0] m;
    logic [T*C-1:0]   v, vb;
    logic [T*R-1:0]   snap;
    logic [3:0]       ssnap;
    bit seen;
    rst = 1; in_valid = 0; out_ready = 1; mtx_in = '0; vec_in = '0;
    step();
    step();
    chk("rst_in_ready", 512'(in_ready), 512'd1);
    chk("rst_out_valid", 512'(out_valid), 512'd0);
    chk("rst_busy", 512'(busy), 512'd0);
    chk("rst_vec_out", vec_out, '0);
    chk("rst_status", 512'(status_out), 512'd0);
    rst = 0;
    step();
    // Identity matrix with x[c] = c*1.0, plus latency
    m = mfill(2'd0);
    for (int r = 0; r < R; r++) m[(r*C+r)*2 +: 2] = 2'd1;
    for (int c = 0; c < C; c++) v[c*T +: T] = T'(c) * 32'h00800000;
    issue(m, v, 1, 0);
    chk("run_busy", 512'(busy), 512'd1);
    chk("run_in_ready", 512'(in_ready), 512'd0);
    repeat (15) step();
    chk("lat_not_yet", 512'(out_valid), 512'd0);
    step();
    chk("lat_valid", 512'(out_valid), 512'd1);
    chk("identity", vec_out, v);
    drain(0);
    // Row 0 all MINUS on 1.0 gives -16.0
    m = mfill(2'd0);
    for (int c = 0; c < C; c++) m[c*2 +: 2] = 2'd2;
    issue(m, vfill(32'h00800000), 1, 0);
    repeat (16) step();
    chk("row0_minus", 512'(vec_out[T-1:0]), 512'(32'hF8000000));
    drain(1);
    issue(mfill(2'd1), vfill(32'h7FFFFFFF), 1, 0);
    drain(1);
    issue(mfill(2'd2), vfill(32'h80000000), 1, 0);
    drain(1);
    issue(mfill(2'd1), vfill(32'h80000000), 1, 0);
    drain(1);
    issue(mfill(2'd0), rvec(), 1, 0);
    drain(1);
    m = mfill(2'd0);
    m[(3*C+5)*2 +: 2] = 2'd3;
    issue(m, rvec(), 1, 0);
    drain(1);
    // Backpressure: result held, in_ready low, a second request ignored
    out_ready = 0;
    m = rmtx();
    v = rvec();
    issue(m, v, 1, 0);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (out_valid) seen = 1;
      else step();
    end
    chk("bp_valid", 512'(seen), 512'd1);
    snap = vec_out;
    ssnap = status_out;
    vb = rvec();
    in_valid = 1;
    mtx_in = mfill(2'd3);
    vec_in = vb;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_vec_stable", vec_out, snap);
      chk("bp_status_stable", 512'(status_out), 512'(ssnap));
      chk("bp_in_ready", 512'(in_ready), 512'd0);
      chk("bp_out_valid", 512'(out_valid), 512'd1);
    end
    in_valid = 0;
    out_ready = 1;
    step();
    chk("bp_release_in_ready", 512'(in_ready), 512'd1);
    chk("bp_release_out_valid", 512'(out_valid), 512'd0);
    issue(mfill(2'd1), vb, 1, 0);
    drain(0);
    // Reset in the middle of RUN discards the operation
    issue(mfill(2'd3), vfill(32'h7FFFFFFF), 0, 0);
    repeat (7) step();
    rst = 1;
    step();
    chk("mid_rst_out_valid", 512'(out_valid), 512'd0);
    chk("mid_rst_busy", 512'(busy), 512'd0);
    chk("mid_rst_in_ready", 512'(in_ready), 512'd1);
    chk("mid_rst_vec_out", vec_out, '0);
    rst = 0;
    step();
    m = mfill(2'd0);
    for (int r = 0; r < R; r++) m[(r*C+(R-1-r))*2 +: 2] = 2'd2;
    issue(m, vfill(32'h00400000), 1, 0);
    drain(0);
    // Random operations with random consumer stalls
    for (int n = 0; n < 25; n++) issue(rmtx(), rvec(), 1, 1);
    drain(1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mtx_mvmul_unit.md
Name: mtx_mvmul_unit

Overview:
- Execution stage for the MVMUL opcode: multiplies a 16x16 ternary matrix (ZERO/PLUS/MINUS, 2-bit codes) by a 16-element signed Q-format vector.
- Processes one row per cycle and writes one saturated element per row into a 16-element result vector, together with a 4-bit status word.
- Sits directly downstream of the M0/V0 register file. The result feeds V1 writeback.

Parameters:
- Q, 23, fractional bits of a vector element
- INT, 8, integer bits of a vector element
- TOTAL, INT+Q+1, element width including sign (derived; do not override)
- R, 16, matrix rows = result length
- C, 16, matrix columns = input vector length

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  operands valid
- in_ready  out  1  unit can accept operands
- mtx_in  in  2*R*C  ternary matrix; element [r][c] at bits [(r*C+c)*2 +: 2]; 00=ZERO, 01=PLUS, 10=MINUS, 11=invalid
- vec_in  in  TOTAL*C  input vector; element c at bits [c*TOTAL +: TOTAL], two's complement
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- vec_out  out  TOTAL*R  result; element r at bits [r*TOTAL +: TOTAL]
- status_out  out  4  {of, uf, zero, inv}, valid while out_valid
- busy  out  1  high in RUN or DONE

Behaviour:
- One clock. Reset is synchronous and active-high; clock port clk, reset port rst.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0
  - vec_out=0, status_out=0, row counter=0
- State IDLE:
  - in_ready=1.
  - When in_valid&in_ready, register mtx_in and vec_in into internal operand registers, clear the sticky flags, set row=0, go to RUN.
- State RUN:
  - in_ready=0.
  - Each cycle, compute sum over c of term(m[row][c], x[c]), where term is: 0 for ZERO, +x for PLUS, −x for MINUS, 0 for the 11 code.
  - Any 11 code in the row sets sticky inv.
  - Sign-extend each x to TOTAL+1 bits before negating, so that −(−2^(TOTAL−1)) is exact.
  - The accumulator is at least TOTAL+5 bits wide; no intermediate wrap.
  - Saturate the sum to [−2^(TOTAL−1), 2^(TOTAL−1)−1]:
    - clip high sets sticky of;
    - clip low sets sticky uf.
  - Write the saturated value to result element [row], then increment row.
  - When row==R−1 is written, go to DONE.
  - A purely combinational 16-term adder tree per row is acceptable; no multipliers are used.
- State DONE:
  - out_valid=1; vec_out and status_out are held stable.
  - zero=1 iff all R result elements equal 0.
  - On out_valid&out_ready, go to IDLE with out_valid=0 in the next cycle.
  - While out_ready is low, hold indefinitely with no change to the outputs.
- Latency:
  - Operands are accepted at edge N.
  - Rows are written on edges N+1 … N+16.
  - out_valid is high from N+16 (i.e. visible in cycle N+17).
  - Minimum issue interval is 18 cycles. in_ready is not asserted in DONE, so there is no overlap.
- in_valid while not in IDLE is ignored; the operands are not captured.
- Input operands may change freely after acceptance; only the registered copies are used.
- vec_out element contents are undefined-but-stable during RUN. Consumers sample only on out_valid.
- Reset mid-RUN or mid-DONE: the current operation is discarded and all outputs return to reset values on the next edge.
- Status flags are sticky for one operation and cleared at the next acceptance.
- Arithmetic is pure integer on Q-format values. No rounding occurs, since ternary weights add no fractional bits.

Test Plan:
- Diagonal PLUS matrix, others ZERO; vec element c = c*0x00800000 (c*1.0) -> after 17 cycles vec_out equals vec_in; status=0000 except zero=0.
- Row 0 all MINUS, other rows ZERO; all x=0x00800000 -> vec_out[0]=0xF8000000 (−16.0), rest 0; status={0,0,0,0}.
- All PLUS, all x=0x7FFFFFFF -> every element 0x7FFFFFFF, of=1. All MINUS, all x=0x80000000 -> every element 0x7FFFFFFF, of=1. All PLUS, all x=0x80000000 -> every element 0x80000000, uf=1.
- All-zero matrix with arbitrary vector -> vec_out all 0, zero=1. Same test with element [3][5]=2'b11 -> zero=1, inv=1.
- Backpressure: out_ready low for 10 cycles after out_valid -> outputs stable, in_ready=0, a second in_valid is ignored. Raise out_ready -> in_ready=1 next cycle; the second operation then completes correctly.
- Assert rst at row 7 of RUN -> next cycle out_valid=0, busy=0, in_ready=1, vec_out=0. A fresh operation then gives correct results with flags not carried over.
